booth_multiplier_seq: RTL and testbench

Parametrised, multi-cycle radix-2 Booth multiplier with a start/done handshake and a runtime signed/unsigned mode. It processes one Booth recoding step per clock, trading latency for a single adder/subtractor. It is the sequential successor to the fixed 4-bit combinational Booth multiplier and sits in the datapath wherever a small-area multiply unit is needed.

---
 rtl/booth_multiplier_seq_pkg.sv | 26 ++
 rtl/booth_multiplier_seq_step.sv | 38 +++
 rtl/booth_multiplier_seq.sv | 97 +++++++++
 tb/tb_booth_multiplier_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and the Booth step operation decode.
package booth_multiplier_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the bit pair {Q[0], Q_-1}.
  function automatic booth_op_t booth_op(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_step.sv
// One combinational Booth step: conditional add/subtract of M into A,
// then an arithmetic right shift of {A, Q, Q_-1} by one bit.
module booth_step
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH+1:0] a_next,
  output logic [WIDTH:0]   q_next,
  output logic             q_m1_next
);

  logic [WIDTH+1:0] m_sext;
  logic [WIDTH+1:0] sum;
  booth_op_t        op;

  assign m_sext = {m[WIDTH], m};
  assign op     = booth_op(q[0], q_m1);

  always_comb begin
    sum = a;
    case (op)
      OP_ADD:  sum = a + m_sext;
      OP_SUB:  sum = a - m_sext;
      default: sum = a;
    endcase
  end

  // A is one bit wider than M, so the sum never overflows before the shift.
  assign a_next    = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_next    = {sum[0], q[WIDTH:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle radix-2 Booth multiplier, one recoding step per clock, with a
// start/done handshake and runtime signed/unsigned operand mode.
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 2);

  state_t             state_reg, state_next;
  logic [WIDTH+1:0]   a_reg;
  logic [WIDTH:0]     q_reg;
  logic               q_m1_reg;
  logic [WIDTH:0]     m_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] z_reg;

  logic [WIDTH+1:0]   a_next;
  logic [WIDTH:0]     q_next;
  logic               q_m1_next;
  logic               last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .m         (m_reg),
    .a_next    (a_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  assign last_step = (count_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are widened by one bit so both modes share the signed datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      q_reg     <= '0;
      q_m1_reg  <= 1'b0;
      m_reg     <= '0;
      count_reg <= '0;
      z_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            m_reg     <= {signed_mode & x[WIDTH-1], x};
            q_reg     <= {signed_mode & y[WIDTH-1], y};
            a_reg     <= '0;
            q_m1_reg  <= 1'b0;
            count_reg <= CW'(WIDTH + 1);
          end
        end
        ST_RUN: begin
          a_reg     <= a_next;
          q_reg     <= q_next;
          q_m1_reg  <= q_m1_next;
          count_reg <= count_reg - CW'(1);
          if (last_step) z_reg <= {a_next[WIDTH-2:0], q_next};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_DONE);
  assign z    = z_reg;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (WIDTH=8): directed corners,
// handshake/abort behaviour and randomized operands against an arithmetic model.
module tb_booth_multiplier_seq;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               signed_mode = 1'b0;
  logic [WIDTH-1:0]   x = '0;
  logic [WIDTH-1:0]   y = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;

  int tests = 0;
  int fails = 0;

  booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .z           (z)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic sm, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    longint pa, pb;
    pa = sm ? longint'($signed(a)) : longint'(a);
    pb = sm ? longint'($signed(b)) : longint'(b);
    return (2*WIDTH)'(pa * pb);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: start at a negedge, then watch from the acceptance edge.
  task automatic do_mult(input string tag, input logic sm, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    int n;
    logic busy_ok;
    logic [2*WIDTH-1:0] exp;
    exp = ref_mul(sm, a, b);
    @(negedge clk);
    start = 1'b1; signed_mode = sm; x = a; y = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; x = $urandom; y = $urandom; signed_mode = ~sm;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'(WIDTH + 1));
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_z"}, z, exp);
    @(negedge clk);
    check({tag, "_done_clr"}, {done, busy}, 2'b00);
    check({tag, "_z_hold"}, z, exp);
    $display("[TB] %s sm=%0d x=%02h y=%02h z=%04h exp=%04h lat=%0d", tag, sm, a, b, z, exp, n);
  endtask

  initial begin
    int n, dones;
    logic [2*WIDTH-1:0] zcap;

    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, z}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    do_mult("t1_5x7",     1'b1, 8'd5,  8'd7);
    do_mult("t2_m3x7",    1'b1, 8'hFD, 8'd7);
    do_mult("t2_7x3",     1'b1, 8'd7,  8'd3);
    do_mult("t3_80x80",   1'b1, 8'h80, 8'h80);
    do_mult("t3_80x7f",   1'b1, 8'h80, 8'h7F);
    do_mult("t3_0x80",    1'b1, 8'h00, 8'h80);
    do_mult("t4_ffxff_u", 1'b0, 8'hFF, 8'hFF);
    do_mult("t4_ffxff_s", 1'b1, 8'hFF, 8'hFF);
    check("t3_const_80x80", ref_mul(1'b1, 8'h80, 8'h80), 16'h4000);

    // Start while running is ignored: one done, original result.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; x = 8'd5; y = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; zcap = '0;
    for (n = 0; n < 20; n++) begin
      if (n == 3) begin start = 1'b1; x = 8'd9; y = 8'd9; signed_mode = 1'b0; end
      if (n == 4) start = 1'b0;
      if (done) begin dones++; zcap = z; end
      @(negedge clk);
    end
    check("t5_done_count", dones, 1);
    check("t5_z", zcap, 16'h0023);
    $display("[TB] t5_ignore_start dones=%0d z=%04h", dones, zcap);

    // Abort by reset in the 4th RUN cycle.
    start = 1'b1; signed_mode = 1'b1; x = 8'd9; y = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_abort_state", {busy, done, z}, '0);
    dones = 0;
    for (n = 0; n < 15; n++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("t6_no_done", dones, 0);
    $display("[TB] t6_abort dones_after=%0d z=%04h", dones, z);
    do_mult("t6_7x3", 1'b1, 8'd7, 8'd3);

    for (int i = 0; i < 25; i++) begin
      do_mult($sformatf("rnd%0d", i), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
